sra8_shared_sequencer: RTL and testbench
========================================

# sra8_shared_sequencer

Iterative arithmetic-right-shift engine shared between two requesters. Each accepted request shifts an NBITS-wide signed operand right by `amt`, one bit position per cycle, with sign fill. A round-robin arbiter grants the single shift datapath, and the result returns on one latency-insensitive val/rdy response port tagged with the requester id. It sits between two producer pipelines and the downstream consumer wherever a full barrel shifter per producer is too costly.

## Interface
- NBITS, 8, operand width; power of two, ≥ 2; AW = $clog2(NBITS) is derived, not a parameter
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- req0_val  input  1  requester 0 valid
- req0_rdy  output  1  requester 0 ready
- req0_in_  input  NBITS  requester 0 operand (two's complement)
- req0_amt  input  AW  requester 0 shift amount
- req1_val / req1_rdy / req1_in_ / req1_amt  same as requester 0, for requester 1
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer ready
- resp_out  output  NBITS  shifted result
- resp_id  output  1  requester that issued this result

## Operation
- FSM states: IDLE, CALC, DONE.
- Round-robin pointer `prio` (1 bit) gives the preferred requester.
- Grant, combinational, in IDLE only:
  - grant = X if reqX_val and (prio == X or other requester's val == 0).
  - reqX_rdy = (state == IDLE) and grant == X.
  - Both rdy are 0 in CALC and DONE, and both are 0 when neither val is set.
- Accept happens when reqX_val and reqX_rdy are both high:
  - data_reg ← reqX_in_, cnt ← reqX_amt, id_reg ← X, prio ← ~X.
  - Next state is DONE if amt == 0, otherwise CALC.
- CALC, each cycle:
  - data_reg ← {data_reg[NBITS-1], data_reg[NBITS-1:1]}, cnt ← cnt − 1.
  - When cnt == 1 (the last shift), next state is DONE.
- DONE:
  - resp_val = 1, resp_out = data_reg, resp_id = id_reg.
  - On resp_val and resp_rdy, go to IDLE.
  - No new accept in the same cycle.
- Arithmetic rule: resp_out always equals in_ arithmetically right-shifted by amt (sign-filled), for every amt in 0..NBITS−1. A negative operand shifted by NBITS−1 gives all ones; a non-negative one gives zero.
- Only one transaction is in flight at a time; there is no input buffering.
- The operand is captured at accept, so requester inputs may change freely afterward.

## Timing
- Reset (reset_n = 0 at a rising edge):
  - state = IDLE, prio = 0, cnt = 0, data_reg = 0, id_reg = 0.
  - Therefore resp_val = 0, resp_out = 0, resp_id = 0, req0_rdy = req1_rdy = 0 until a val arrives.
- Reset mid-operation (CALC or DONE): the transaction is discarded with no response, and prio returns to 0.
- Latency, with the accept cycle as cycle 0:
  - resp_val first rises in cycle amt + 1 (amt = 0 gives cycle 1).
  - resp_val stays high until the handshake.
- Throughput: one result per amt + 2 cycles, assuming resp_rdy = 1 (accept, amt shifts, DONE).
- Response hold: while resp_val = 1 and resp_rdy = 0, resp_out and resp_id are stable.
- Simultaneous req0_val and req1_val in IDLE: the prio requester wins, then the pointer flips. Sustained contention therefore alternates 0, 1, 0, …
- A requester that drops val before a grant loses nothing; there is no reservation.

## Configuration
- SRA_SEQ_BARREL_EN defined:
  - The CALC state and counter are not instantiated.
  - At accept, data_reg ← sign-filled shift of in_ by amt in one combinational step, and next state is DONE.
  - Latency is fixed at 1 cycle for every amt; throughput is one result per 2 cycles.
- Undefined (default): iterative 1-bit/cycle behaviour exactly as above.
- Arbitration, handshake, reset behaviour and results are identical in both builds; only timing differs.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with req0_val = 1, then release with all vals 0 → resp_val = 0, resp_out = 0x00, both rdy = 0.
- Single shift: req0 in_ = 0x80, amt = 3, resp_rdy = 1 → resp_val in cycle 4, resp_out = 0xF0, resp_id = 0. With SRA_SEQ_BARREL_EN, resp_val is in cycle 1.
- Zero and maximum shift, positive and negative operands:
  - req1 0x5A, amt 0 → 0x5A, resp_val in cycle 1.
  - 0x81, amt 7 → 0xFF.
  - 0x7F, amt 7 → 0x00.
- Contention: both vals held high, req0 = (0x81, 1), req1 = (0x40, 2) → responses in the order id 0 (0xC0), id 1 (0x10), id 0, id 1, …; req0 is granted first after reset.
- Backpressure: resp_rdy = 0 for 5 cycles in DONE → resp_val, resp_out and resp_id are stable, both rdy = 0, no new accept. After resp_rdy = 1, IDLE is reached the next cycle.
- Reset mid-CALC: req0 0x80, amt 7; assert reset_n = 0 in cycle 3 → no response is issued, state returns to IDLE, and the next contended grant goes to req0.

Source files
------------

// File: rtl/sra8_shared_sequencer.sv
// Two-requester round-robin arithmetic right shifter; latency amt+1 (1 with SRA_SEQ_BARREL_EN), one result per amt+2 cycles.
// Backpressure: both req rdy low while busy; result held in DONE until resp_rdy, no input buffering.
module sra8_shared_sequencer #(
    parameter int NBITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [NBITS-1:0]         req0_in_,
    input  logic [$clog2(NBITS)-1:0] req0_amt,
    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [NBITS-1:0]         req1_in_,
    input  logic [$clog2(NBITS)-1:0] req1_amt,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic [NBITS-1:0]         resp_out,
    output logic                     resp_id
);
    localparam int AW = $clog2(NBITS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic             r_prio;
    logic             r_id;
    logic [NBITS-1:0] r_data;
`ifndef SRA_SEQ_BARREL_EN
    logic [AW-1:0]    r_cnt;
`endif

    logic             w_idle;
    logic             w_g0;
    logic             w_g1;
    logic             w_acc;
    logic             w_sel;
    logic [NBITS-1:0] w_in;
    logic [AW-1:0]    w_amt;

    // The preferred requester wins a tie; a lone requester always wins.
    assign w_idle   = (r_state == IDLE);
    assign w_g0     = req0_val && (!r_prio || !req1_val);
    assign w_g1     = req1_val && (r_prio || !req0_val);
    assign req0_rdy = w_idle && w_g0;
    assign req1_rdy = w_idle && w_g1;
    assign w_acc    = req0_rdy || req1_rdy;
    assign w_sel    = req1_rdy;
    assign w_in     = w_sel ? req1_in_ : req0_in_;
    assign w_amt    = w_sel ? req1_amt : req0_amt;

    assign resp_val = (r_state == DONE);
    assign resp_out = r_data;
    assign resp_id  = r_id;

`ifdef SRA_SEQ_BARREL_EN
    logic [NBITS-1:0] w_shifted;
    assign w_shifted = $signed(w_in) >>> w_amt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_id    <= 1'b0;
            r_data  <= '0;
`ifndef SRA_SEQ_BARREL_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_id   <= w_sel;
                        r_prio <= ~w_sel;
`ifdef SRA_SEQ_BARREL_EN
                        r_data  <= w_shifted;
                        r_state <= DONE;
`else
                        r_data  <= w_in;
                        r_cnt   <= w_amt;
                        r_state <= (w_amt == '0) ? DONE : CALC;
`endif
                    end
                end
`ifndef SRA_SEQ_BARREL_EN
                CALC: begin
                    r_data <= {r_data[NBITS-1], r_data[NBITS-1:1]};
                    r_cnt  <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (resp_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sra8_shared_sequencer.sv
// Bench for sra8_shared_sequencer: directed table, corner sequences, then randomized scoreboard run.
module tb_sra8_shared_sequencer;
    localparam int NBITS = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0_val, req0_rdy, req1_val, req1_rdy;
    logic [NBITS-1:0] req0_in_, req1_in_;
    logic [AW-1:0]    req0_amt, req1_amt;
    logic             resp_val, resp_rdy, resp_id;
    logic [NBITS-1:0] resp_out;

    int nvec = 0;
    int nbad = 0;

    sra8_shared_sequencer #(.NBITS(NBITS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_in_(req0_in_), .req0_amt(req0_amt),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_in_(req1_in_), .req1_amt(req1_amt),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_out(resp_out), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] din;
        logic [2:0] amt;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division by 2^a on the signed value, independent of any shift operator.
    function automatic logic [7:0] sra_model(input logic [7:0] v, input int a);
        int x;
        int d;
        x = $signed(v);
        d = 1 << a;
        if (x >= 0) x = x / d;
        else        x = -((-x + d - 1) / d);
        return 8'(x);
    endfunction

    function automatic int exp_lat(input int amt);
`ifdef SRA_SEQ_BARREL_EN
        return 1;
`else
        return amt + 1;
`endif
    endfunction

    task automatic run_one(input vec_t v);
        int lat;
        @(negedge clk);
        resp_rdy = 1'b1;
        if (v.id) begin
            req1_val = 1'b1; req1_in_ = v.din; req1_amt = v.amt;
        end else begin
            req0_val = 1'b1; req0_in_ = v.din; req0_amt = v.amt;
        end
        #1;
        check("tbl_rdy", v.id ? req1_rdy : req0_rdy, 1);
        @(posedge clk); #1;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_in_ = 8'hA5; req1_in_ = 8'h3C; req0_amt = 3'd5; req1_amt = 3'd6;
        lat = 1;
        while (!resp_val && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("tbl_latency", lat, exp_lat(v.amt));
        check("tbl_out", resp_out, v.dout);
        check("tbl_id", resp_id, v.id);
        @(posedge clk); #1;
        check("tbl_idle_after", resp_val, 0);
    endtask

    initial begin
        int   n;
        logic m_prio, m_busy, m_id, e_rdy0, e_rdy1, e_val;
        logic [7:0] m_out;
        int   m_lat, acc_cyc;

        reset_n  = 1'b0;
        req0_val = 1'b1; req1_val = 1'b0; resp_rdy = 1'b0;
        req0_in_ = '0; req1_in_ = '0; req0_amt = '0; req1_amt = '0;

        tbl[0] = '{1'b0, 8'h80, 3'd3, 8'hF0};
        tbl[1] = '{1'b1, 8'h5A, 3'd0, 8'h5A};
        tbl[2] = '{1'b0, 8'h81, 3'd7, 8'hFF};
        tbl[3] = '{1'b1, 8'h7F, 3'd7, 8'h00};
        tbl[4] = '{1'b1, 8'h80, 3'd7, 8'hFF};
        tbl[5] = '{1'b0, 8'hF3, 3'd2, 8'hFC};
        tbl[6] = '{1'b1, 8'h37, 3'd5, 8'h01};

        // Reset with a requester pending, then release idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; req0_val = 1'b0;
        #1;
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_out", resp_out, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_rdy0", req0_rdy, 0);
        check("rst_rdy1", req1_rdy, 0);

        // Contention from reset: req0 first, then strict alternation.
        @(negedge clk);
        resp_rdy = 1'b1;
        req0_val = 1'b1; req0_in_ = 8'h81; req0_amt = 3'd1;
        req1_val = 1'b1; req1_in_ = 8'h40; req1_amt = 3'd2;
        #1;
        check("cont_first_rdy0", req0_rdy, 1);
        check("cont_first_rdy1", req1_rdy, 0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!resp_val && n < 40);
            check("cont_resp_val", resp_val, 1);
            check("cont_id", resp_id, k % 2);
            check("cont_out", resp_out, (k % 2) ? 8'h10 : 8'hC0);
        end
        req0_val = 1'b0; req1_val = 1'b0;
        repeat (2) @(posedge clk);

        // Directed single-requester table (prio is 0 here after the last id-1 grant).
        for (int i = 0; i < 7; i++) run_one(tbl[i]);

        // Backpressure: result and id held, no accept while stalled.
        @(negedge clk);
        resp_rdy = 1'b0;
        req0_val = 1'b1; req0_in_ = 8'h80; req0_amt = 3'd3;
        @(posedge clk); #1;
        req0_val = 1'b0; req1_val = 1'b1; req1_in_ = 8'h11; req1_amt = 3'd1;
        n = 0;
        while (!resp_val && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_val", resp_val, 1);
            check("bp_out", resp_out, 8'hF0);
            check("bp_id", resp_id, 0);
            check("bp_rdy0", req0_rdy, 0);
            check("bp_rdy1", req1_rdy, 0);
            @(posedge clk); #1;
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_val", resp_val, 0);
        check("bp_release_rdy1", req1_rdy, 1);
        req1_val = 1'b0;
        @(posedge clk);

        // Reset in the middle of a long shift discards it and restores prio to 0.
        @(negedge clk);
        resp_rdy = 1'b0;
        req0_val = 1'b1; req0_in_ = 8'h80; req0_amt = 3'd7;
        @(posedge clk); #1;
        req0_val = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n  = 1'b1;
        resp_rdy = 1'b1;
        n = 0;
        repeat (12) begin
            if (resp_val) n++;
            @(posedge clk); #1;
        end
        check("midrst_no_resp", n, 0);
        @(negedge clk);
        req0_val = 1'b1; req1_val = 1'b1;
        #1;
        check("midrst_rdy0", req0_rdy, 1);
        check("midrst_rdy1", req1_rdy, 0);
        req0_val = 1'b0; req1_val = 1'b0;

        // Randomized traffic against a transaction-level scoreboard.
        m_prio = 1'b0; m_busy = 1'b0; m_id = 1'b0; m_out = '0; m_lat = 0; acc_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req0_val = ($urandom_range(0, 2) != 0);
            req1_val = ($urandom_range(0, 2) != 0);
            req0_in_ = 8'($urandom); req0_amt = 3'($urandom);
            req1_in_ = 8'($urandom); req1_amt = 3'($urandom);
            resp_rdy = ($urandom_range(0, 3) != 0);
            #1;
            e_rdy0 = !m_busy && req0_val && (!m_prio || !req1_val);
            e_rdy1 = !m_busy && req1_val && (m_prio || !req0_val);
            e_val  = m_busy && (c - acc_cyc >= m_lat);
            check("rnd_rdy0", req0_rdy, e_rdy0);
            check("rnd_rdy1", req1_rdy, e_rdy1);
            check("rnd_resp_val", resp_val, e_val);
            if (e_val) begin
                check("rnd_out", resp_out, m_out);
                check("rnd_id", resp_id, m_id);
            end
            if (e_val && resp_rdy) begin
                m_busy = 1'b0;
            end else if (e_rdy0 || e_rdy1) begin
                m_id    = e_rdy1;
                m_out   = e_rdy1 ? sra_model(req1_in_, req1_amt) : sra_model(req0_in_, req0_amt);
                m_lat   = exp_lat(e_rdy1 ? req1_amt : req0_amt);
                acc_cyc = c;
                m_busy  = 1'b1;
                m_prio  = ~e_rdy1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
